fcpu_loader: RTL and testbench
==============================

FCPU_LOADER -- requirements
Module: fcpu_loader

Interface
REQ-001 The block SHALL have parameter CRAM_ADDR_W, default 10, code-RAM word address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, code-RAM word width; fixed at 32 (4 bytes per word).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 rx_data  input  8  byte from serial interface receive stream.
REQ-006 rx_valid  input  1  rx_data valid.
REQ-007 rx_ready  output  1  loader or core accepts rx byte.
REQ-008 core_i_data  output  8  byte forwarded to core input port.
REQ-009 core_i_valid  output  1  core_i_data valid.
REQ-010 core_i_ready  input  1  core accepts byte.
REQ-011 wr_en  output  1  code-RAM write strobe, one-cycle pulse.
REQ-012 wr_addr  output  CRAM_ADDR_W  code-RAM write address.
REQ-013 wr_data  output  DATA_W  code-RAM write data.
REQ-014 core_run  output  1  1 = core released from reset and owns the rx stream.
REQ-015 boot_req  input  1  request to reload the program; sampled only in RUN.
REQ-016 load_err  output  1  sticky: image exceeded code-RAM depth.

Function
REQ-017 States SHALL be LEN_HI, LEN_LO, WORD, RUN.
REQ-018 Byte transfer SHALL occur when rx_valid and rx_ready are both 1 in the same cycle.
REQ-019 In LEN_HI, LEN_LO and WORD, rx_ready SHALL be 1, core_i_valid SHALL be 0, and core_run SHALL be 0.
REQ-020 LEN_HI SHALL capture the byte as word count N[15:8] and go to LEN_LO.
REQ-021 LEN_LO SHALL capture N[7:0] and go to WORD if N != 0; if N == 0 it SHALL go directly to RUN.
REQ-022 WORD SHALL assemble 4 bytes big-endian (first byte -> bits 31:24) using a 2-bit byte counter.
REQ-023 On acceptance of the 4th byte, wr_en SHALL pulse high for exactly the next cycle.
REQ-024 During that pulse, wr_data SHALL hold the assembled word and wr_addr SHALL hold the word index (0, 1, 2, ...).
REQ-025 The word index SHALL be CRAM_ADDR_W+1 bits wide.
REQ-026 A word with index >= 2**CRAM_ADDR_W SHALL be consumed without a wr_en pulse, and it SHALL set load_err.
REQ-027 After the 4th byte of word N-1 is accepted, the state SHALL go to RUN.
REQ-028 core_run SHALL rise exactly one cycle after the final wr_en pulse, or one cycle after the LEN_LO byte when N == 0.
REQ-029 wr_en SHALL never be high in the same cycle as core_run rising.
REQ-030 In RUN with core_run=1, the rx stream SHALL pass through combinationally: core_i_data=rx_data, core_i_valid=rx_valid, rx_ready=core_i_ready.
REQ-031 In RUN, boot_req=1 SHALL cause core_run=0, rx_ready=0 and core_i_valid=0 in the next cycle, and a return to LEN_HI with counters cleared.
REQ-032 load_err SHALL be cleared when a reload starts via boot_req.
REQ-033 boot_req SHALL be ignored outside RUN.
REQ-034 Idle cycles (rx_valid=0) in any load state SHALL hold all state; there is no timeout.
REQ-035 The word count range SHALL be 0..65535; the word index SHALL not wrap; no writes SHALL be issued past the RAM depth.

Reset
REQ-036 On nrst=0, asynchronously: state=LEN_HI, byte counter=0, word index=0, N=0.
REQ-037 On nrst=0, asynchronously: wr_en=0, wr_addr=0, wr_data=0, core_run=0, load_err=0.
REQ-038 Reset asserted mid-load SHALL abort the load; the next byte after release SHALL be treated as N[15:8].
REQ-039 Code-RAM contents SHALL not be altered by reset.

Verification
REQ-040 Load 2 words: bytes 00 02 12 34 56 78 9A BC DE F0 -> wr_en pulses at addr 0 data 0x12345678 and addr 1 data 0x9ABCDEF0; core_run=1 one cycle after the second pulse.
REQ-041 Zero-length image: bytes 00 00 -> no wr_en; core_run=1 one cycle after the second byte; next byte 0x41 with core_i_ready=1 appears on core_i_data with core_i_valid=1.
REQ-042 Gaps/backpressure: rx_valid toggling 1-0-1 within a word -> identical wr_data; in RUN with core_i_ready=0 -> rx_ready=0 and the byte is held.
REQ-043 Overflow with CRAM_ADDR_W=2: N=5, 20 bytes -> exactly 4 wr_en pulses (addr 0-3), load_err=1, core_run=1 after the 20th byte.
REQ-044 Reload: in RUN, boot_req=1 for 1 cycle -> core_run=0 next cycle; bytes 00 01 AA BB CC DD -> write addr 0 = 0xAABBCCDD; core_run=1 again.
REQ-045 Reset mid-word: nrst low after 2 bytes of word 0 -> all outputs 0; the fresh sequence 00 01 11 22 33 44 writes 0x11223344 at addr 0.

Source files
------------

// File: rtl/fcpu_loader.sv
// rtl/fcpu_loader.sv - serial boot loader: length-prefixed big-endian image into code RAM, then rx pass-through to core
module fcpu_loader #(
  parameter int CRAM_ADDR_W = 10,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             core_i_data,
  output logic                   core_i_valid,
  input  logic                   core_i_ready,
  output logic                   wr_en,
  output logic [CRAM_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   core_run,
  input  logic                   boot_req,
  output logic                   load_err
);

  typedef enum logic [1:0] {LEN_HI, LEN_LO, WORD, RUN} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            len_q;
  logic [1:0]             byte_cnt_q;
  logic [CRAM_ADDR_W:0]   idx_q;
  logic [23:0]            shift_q;
  logic                   boot_pend_q;
  logic [15:0]            len_next;

  assign len_next = {len_q[15:8], rx_data};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= LEN_HI;
    else       state_q <= state_d;
  end

  // Core sees the rx stream only once core_run is up; the RUN cycle before that is a dead cycle.
  always_comb begin
    state_d      = state_q;
    rx_ready     = 1'b0;
    core_i_valid = 1'b0;
    core_i_data  = 8'h00;
    case (state_q)
      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_d = (len_next == 16'd0) ? RUN : WORD;
      end
      WORD: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_cnt_q == 2'd3 && len_q == 16'd1) state_d = RUN;
      end
      RUN: begin
        if (core_run) begin
          rx_ready     = core_i_ready;
          core_i_valid = rx_valid;
          core_i_data  = rx_data;
        end else if (boot_pend_q) begin
          state_d = LEN_HI;
        end
      end
      default: state_d = LEN_HI;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      len_q       <= '0;
      byte_cnt_q  <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      boot_pend_q <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      core_run    <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state_q)
        LEN_HI: if (rx_valid) len_q[15:8] <= rx_data;
        LEN_LO: if (rx_valid) begin
          len_q[7:0] <= rx_data;
          if (len_next == 16'd0) core_run <= 1'b1;
        end
        WORD: if (rx_valid) begin
          shift_q    <= {shift_q[15:0], rx_data};
          byte_cnt_q <= byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            len_q <= len_q - 16'd1;
            // Index saturates at the RAM depth so words past the end are dropped, never wrapped.
            if (!idx_q[CRAM_ADDR_W]) begin
              wr_en   <= 1'b1;
              wr_addr <= idx_q[CRAM_ADDR_W-1:0];
              wr_data <= {shift_q, rx_data};
              idx_q   <= idx_q + {{CRAM_ADDR_W{1'b0}}, 1'b1};
            end else begin
              load_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (core_run) begin
            if (boot_req) begin
              core_run    <= 1'b0;
              boot_pend_q <= 1'b1;
              len_q       <= '0;
              byte_cnt_q  <= '0;
              idx_q       <= '0;
              shift_q     <= '0;
              load_err    <= 1'b0;
            end
          end else if (boot_pend_q) begin
            boot_pend_q <= 1'b0;
          end else begin
            core_run <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fcpu_loader.sv
// tb/tb_fcpu_loader.sv - directed self-checking bench for fcpu_loader (code RAM depth 4)
module tb_fcpu_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    core_i_data;
  logic          core_i_valid;
  logic          core_i_ready = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          core_run;
  logic          boot_req = 1'b0;
  logic          load_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wn = 0;
  logic [AW-1:0] wa [0:15];
  logic [31:0]   wd [0:15];

  fcpu_loader #(.CRAM_ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .core_i_data(core_i_data), .core_i_valid(core_i_valid), .core_i_ready(core_i_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .core_run(core_run),
    .boot_req(boot_req), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en && wn < 16) begin
      wa[wn] = wr_addr;
      wd[wn] = wr_data;
      wn++;
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge with rx_valid low.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    #1;
    while (!rx_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    total_cnt++;
    if (!rx_ready) begin
      $display("FAIL send_byte_timeout: rx_ready=%0b required 1 for byte %h", rx_ready, b);
      rx_valid = 1'b0;
      @(negedge clk);
    end else begin
      pass_cnt++;
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    rx_valid = 1'b0;
    boot_req = 1'b0;
    core_i_ready = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    wn = 0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #1;
    total_cnt++; if ({wr_en, wr_addr, wr_data, core_run, load_err} !== '0) $display("FAIL reset_outputs: got %h required 0", {wr_en, wr_addr, wr_data, core_run, load_err}); else pass_cnt++;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b required 1", rx_ready); else pass_cnt++;
    total_cnt++; if (core_i_valid !== 1'b0) $display("FAIL reset_core_i_valid: got %b required 0", core_i_valid); else pass_cnt++;
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    wn = 0;
  endtask

  task automatic test_two_words();
    logic [7:0] bytes [0:9];
    bytes = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    for (int i = 0; i < 6; i++) send_byte(bytes[i]);
    total_cnt++; if (wr_en !== 1'b1 || wr_addr !== 2'd0 || wr_data !== 32'h12345678) $display("FAIL two_words_w0: en=%b addr=%0d data=%h required 1/0/12345678", wr_en, wr_addr, wr_data); else pass_cnt++;
    for (int i = 6; i < 10; i++) send_byte(bytes[i]);
    total_cnt++; if (wr_en !== 1'b1 || wr_addr !== 2'd1 || wr_data !== 32'h9ABCDEF0) $display("FAIL two_words_w1: en=%b addr=%0d data=%h required 1/1/9abcdef0", wr_en, wr_addr, wr_data); else pass_cnt++;
    total_cnt++; if (core_run !== 1'b0) $display("FAIL two_words_run_early: core_run=%b required 0", core_run); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (core_run !== 1'b1 || wr_en !== 1'b0) $display("FAIL two_words_run: core_run=%b wr_en=%b required 1/0", core_run, wr_en); else pass_cnt++;
    total_cnt++; if (wn !== 2) $display("FAIL two_words_count: pulses=%0d required 2", wn); else pass_cnt++;
  endtask

  task automatic test_zero_length();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    total_cnt++; if (core_run !== 1'b1 || wr_en !== 1'b0) $display("FAIL zero_run: core_run=%b wr_en=%b required 1/0", core_run, wr_en); else pass_cnt++;
    rx_data = 8'h41; rx_valid = 1'b1; core_i_ready = 1'b1;
    #1;
    total_cnt++; if (core_i_data !== 8'h41 || core_i_valid !== 1'b1 || rx_ready !== 1'b1) $display("FAIL zero_passthru: data=%h valid=%b ready=%b required 41/1/1", core_i_data, core_i_valid, rx_ready); else pass_cnt++;
    core_i_ready = 1'b0;
    #1;
    total_cnt++; if (rx_ready !== 1'b0 || core_i_valid !== 1'b1 || core_i_data !== 8'h41) $display("FAIL zero_backpressure: ready=%b valid=%b data=%h required 0/1/41", rx_ready, core_i_valid, core_i_data); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (core_i_data !== 8'h41 || rx_ready !== 1'b0) $display("FAIL zero_hold: data=%h ready=%b required 41/0", core_i_data, rx_ready); else pass_cnt++;
    rx_valid = 1'b0;
    total_cnt++; if (wn !== 0) $display("FAIL zero_no_write: pulses=%0d required 0", wn); else pass_cnt++;
  endtask

  task automatic test_gaps();
    do_reset();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34);
    boot_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++; if (rx_ready !== 1'b1 || core_run !== 1'b0) $display("FAIL gaps_idle: ready=%b core_run=%b required 1/0", rx_ready, core_run); else pass_cnt++;
    boot_req = 1'b0;
    send_byte(8'h56);
    @(negedge clk);
    send_byte(8'h78);
    total_cnt++; if (wr_en !== 1'b1 || wr_addr !== 2'd0 || wr_data !== 32'h12345678) $display("FAIL gaps_word: en=%b addr=%0d data=%h required 1/0/12345678", wr_en, wr_addr, wr_data); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (core_run !== 1'b1) $display("FAIL gaps_run: core_run=%b required 1", core_run); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h00); send_byte(8'h05);
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1));
    total_cnt++; if (load_err !== 1'b1 || wr_en !== 1'b0 || core_run !== 1'b0) $display("FAIL ovf_end: err=%b wr_en=%b core_run=%b required 1/0/0", load_err, wr_en, core_run); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (core_run !== 1'b1) $display("FAIL ovf_run: core_run=%b required 1", core_run); else pass_cnt++;
    total_cnt++; if (wn !== 4) $display("FAIL ovf_count: pulses=%0d required 4", wn); else pass_cnt++;
    total_cnt++; if (wa[0] !== 2'd0 || wd[0] !== 32'h01020304) $display("FAIL ovf_w0: addr=%0d data=%h required 0/01020304", wa[0], wd[0]); else pass_cnt++;
    total_cnt++; if (wa[3] !== 2'd3 || wd[3] !== 32'h0D0E0F10) $display("FAIL ovf_w3: addr=%0d data=%h required 3/0d0e0f10", wa[3], wd[3]); else pass_cnt++;
  endtask

  task automatic test_reload();
    wn = 0;
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    #1;
    total_cnt++; if (core_run !== 1'b0 || rx_ready !== 1'b0 || core_i_valid !== 1'b0) $display("FAIL reload_stop: core_run=%b ready=%b valid=%b required 0/0/0", core_run, rx_ready, core_i_valid); else pass_cnt++;
    total_cnt++; if (load_err !== 1'b0) $display("FAIL reload_err_clear: load_err=%b required 0", load_err); else pass_cnt++;
    @(negedge clk);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    total_cnt++; if (wr_en !== 1'b1 || wr_addr !== 2'd0 || wr_data !== 32'hAABBCCDD) $display("FAIL reload_word: en=%b addr=%0d data=%h required 1/0/aabbccdd", wr_en, wr_addr, wr_data); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (core_run !== 1'b1) $display("FAIL reload_run: core_run=%b required 1", core_run); else pass_cnt++;
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    nrst = 1'b0;
    #1;
    total_cnt++; if ({wr_en, wr_addr, wr_data, core_run, load_err} !== '0) $display("FAIL midreset_outputs: got %h required 0", {wr_en, wr_addr, wr_data, core_run, load_err}); else pass_cnt++;
    @(negedge clk);
    nrst = 1'b1;
    wn = 0;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    total_cnt++; if (wr_en !== 1'b1 || wr_addr !== 2'd0 || wr_data !== 32'h11223344) $display("FAIL midreset_word: en=%b addr=%0d data=%h required 1/0/11223344", wr_en, wr_addr, wr_data); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (core_run !== 1'b1 || wn !== 1) $display("FAIL midreset_run: core_run=%b pulses=%0d required 1/1", core_run, wn); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_length();
    test_gaps();
    test_overflow();
    test_reload();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
